// File: rtl/mult_pkg.sv
// Shared definitions for the 16x9 shift-add sequential multiplier:
// controller state encoding, default sizing and datapath widths.
package mult_pkg;

  // Default controller sizing: one iteration per multiplier bit.
  localparam int N_BITS_DEF = 9;
  localparam int CNT_W_DEF  = 4;

  // Operand and product widths used by the datapath and the top level.
  localparam int MX_W   = 16;
  localparam int MY_W   = 9;
  localparam int PROD_W = MX_W + MY_W;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    DONE_ST = 2'd3
  } state_e;

  // Registered-state datapath strobes. ADD_EN is kept separate because it
  // also depends on the live multiplier LSB.
  typedef struct packed {
    logic load_mx;
    logic load_my;
    logic clr_acc;
    logic sft_my;
    logic sft_acc;
  } strobes_t;

endpackage : mult_pkg

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier controller: synchronous clear,
// count enable, and a terminal flag raised on the final iteration index.
module iter_counter #(
  parameter int CNT_W  = 4,
  parameter int N_BITS = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(N_BITS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable; otherwise hold.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == LAST_VAL);

endmodule : iter_counter

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the 16x9 shift-add sequential multiplier. Accepts a start
// request, loads operands and clears the accumulator for one cycle, runs one
// add/shift iteration per multiplier bit, then holds DONE until ACK.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ACK,
  input  logic             MY_BIT,
  output logic             READY,
  output logic             LOAD_MX,
  output logic             LOAD_MY,
  output logic             CLR_ACC,
  output logic             SFT_MY,
  output logic             ADD_EN,
  output logic             SFT_ACC,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT
);

  state_e   state_q;
  state_e   state_d;
  logic     cnt_clr;
  logic     cnt_en;
  logic     cnt_last;
  strobes_t strb;

  // Iteration index; cleared on entry to RUN, on abort and on leaving DONE_ST.
  iter_counter #(
    .CNT_W  (CNT_W),
    .N_BITS (N_BITS)
  ) u_iter_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (COUNT),
    .last  (cnt_last)
  );

  // Next-state and counter control; ABORT outranks the normal progression.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_clr = 1'b1;
        state_d = ABORT ? IDLE : RUN;
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_last) begin
          // Final iteration: COUNT holds at N_BITS-1 through DONE_ST.
          state_d = DONE_ST;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE_ST: begin
        if (ACK) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe decode from registered state only.
  always_comb begin
    strb = '0;
    case (state_q)
      LOAD: begin
        strb.load_mx = 1'b1;
        strb.load_my = 1'b1;
        strb.clr_acc = 1'b1;
      end
      RUN: begin
        strb.sft_my  = 1'b1;
        strb.sft_acc = 1'b1;
      end
      default: begin
        strb = '0;
      end
    endcase
  end

  assign LOAD_MX = strb.load_mx;
  assign LOAD_MY = strb.load_my;
  assign CLR_ACC = strb.clr_acc;
  assign SFT_MY  = strb.sft_my;
  assign SFT_ACC = strb.sft_acc;

  // The only Mealy output: add the multiplicand when the live LSB is set.
  assign ADD_EN  = (state_q == RUN) && MY_BIT;

  assign READY   = (state_q == IDLE);
  assign BUSY    = (state_q == LOAD) || (state_q == RUN);
  assign DONE    = (state_q == DONE_ST);

endmodule : mult_seq_ctrl

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: two instances (N_BITS=9 and 4), each
// driving a bench-side shift-add datapath, checked every cycle against an
// elapsed-cycle model of the operation schedule plus a plain product.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic start   [2];
  logic abort_i [2];
  logic ack     [2];
  logic my_bit  [2];
  logic ready   [2];
  logic load_mx [2];
  logic load_my [2];
  logic clr_acc [2];
  logic sft_my  [2];
  logic add_en  [2];
  logic sft_acc [2];
  logic busy    [2];
  logic done    [2];
  logic [3:0] cnt [2];
  logic [3:0] cnt9;
  logic [2:0] cnt4;

  int nb [2] = '{9, 4};

  int n_checks = 0;
  int n_errors = 0;

  // Operand inputs and bench-side datapath.
  logic [MX_W-1:0] mx_in [2];
  logic [MY_W-1:0] my_in [2];
  longint mxr [2] = '{0, 0};
  longint myr [2] = '{0, 0};
  longint acc [2] = '{0, 0};

  // Strobes sampled mid-cycle for the datapath update at the next edge.
  logic s_lmx [2], s_lmy [2], s_clr [2], s_smy [2], s_add [2], s_sacc [2];

  // Model: m_e = cycles into the operation (0 idle, 1 load, 2..N+1 run,
  // N+2 done); m_cv says whether COUNT is defined in idle/load.
  int     m_e    [2] = '{0, 0};
  bit     m_cv   [2] = '{1'b1, 1'b1};
  longint m_prod [2] = '{0, 0};
  int     load_cnt [2] = '{0, 0};

  assign cnt[0]    = cnt9;
  assign cnt[1]    = {1'b0, cnt4};
  assign my_bit[0] = myr[0][0];
  assign my_bit[1] = myr[1][0];

  mult_seq_ctrl #(.N_BITS(9), .CNT_W(4)) dut9 (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .ABORT(abort_i[0]),
    .ACK(ack[0]), .MY_BIT(my_bit[0]), .READY(ready[0]), .LOAD_MX(load_mx[0]),
    .LOAD_MY(load_my[0]), .CLR_ACC(clr_acc[0]), .SFT_MY(sft_my[0]),
    .ADD_EN(add_en[0]), .SFT_ACC(sft_acc[0]), .BUSY(busy[0]), .DONE(done[0]),
    .COUNT(cnt9)
  );

  mult_seq_ctrl #(.N_BITS(4), .CNT_W(3)) dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .ABORT(abort_i[1]),
    .ACK(ack[1]), .MY_BIT(my_bit[1]), .READY(ready[1]), .LOAD_MX(load_mx[1]),
    .LOAD_MY(load_my[1]), .CLR_ACC(clr_acc[1]), .SFT_MY(sft_my[1]),
    .ADD_EN(add_en[1]), .SFT_ACC(sft_acc[1]), .BUSY(busy[1]), .DONE(done[1]),
    .COUNT(cnt4)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] out_vec(input int d);
    return {ready[d], busy[d], done[d], load_mx[d], load_my[d], clr_acc[d],
            sft_my[d], add_en[d], sft_acc[d]};
  endfunction

  // Model advance and bench datapath update on each rising edge.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_e[d]  = 0;
        m_cv[d] = 1'b1;
      end else begin
        if (m_e[d] == 0) begin
          if (start[d]) m_e[d] = 1;
        end else if (m_e[d] <= nb[d] + 1) begin
          if (abort_i[d]) begin
            m_e[d]  = 0;
            m_cv[d] = 1'b1;
          end else begin
            if (m_e[d] == 1) begin
              m_cv[d]   = 1'b1;
              m_prod[d] = longint'(mx_in[d]) *
                          (longint'(my_in[d]) & ((64'd1 << nb[d]) - 1));
            end
            m_e[d]++;
          end
        end else if (ack[d]) begin
          m_e[d]  = 0;
          m_cv[d] = 1'b0;
        end
        // Datapath driven purely by the DUT strobes seen this cycle.
        if (s_lmx[d]) mxr[d] = longint'(mx_in[d]);
        if (s_lmy[d]) myr[d] = longint'(my_in[d]) & ((64'd1 << nb[d]) - 1);
        if (s_clr[d]) acc[d] = 0;
        if (s_sacc[d]) acc[d] = (acc[d] + (s_add[d] ? (mxr[d] << nb[d]) : 64'd0)) >> 1;
        if (s_smy[d]) myr[d] = myr[d] >> 1;
      end
    end
  end

  // Mid-cycle sampling and per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [8:0] exp_v;
      bit in_run;
      s_lmx[d]  = load_mx[d];
      s_lmy[d]  = load_my[d];
      s_clr[d]  = clr_acc[d];
      s_smy[d]  = sft_my[d];
      s_add[d]  = add_en[d];
      s_sacc[d] = sft_acc[d];
      if (load_mx[d] === 1'b1) load_cnt[d]++;
      if (rst_n) begin
        in_run = (m_e[d] >= 2) && (m_e[d] <= nb[d] + 1);
        exp_v = {m_e[d] == 0, (m_e[d] >= 1) && in_run || m_e[d] == 1,
                 m_e[d] == nb[d] + 2, m_e[d] == 1, m_e[d] == 1, m_e[d] == 1,
                 in_run, in_run && my_bit[d], in_run};
        check($sformatf("outputs[%0d]", d), 64'(out_vec(d)), 64'(exp_v));
        if (in_run) begin
          check($sformatf("count_run[%0d]", d), 64'(cnt[d]), 64'(m_e[d] - 2));
        end else if (m_e[d] == nb[d] + 2) begin
          check($sformatf("count_done[%0d]", d), 64'(cnt[d]), 64'(nb[d] - 1));
          check($sformatf("product[%0d]", d), acc[d], m_prod[d]);
        end else if (m_cv[d]) begin
          check($sformatf("count_idle[%0d]", d), 64'(cnt[d]), 64'd0);
        end
      end
    end
  end

  // Wait for DONE on instance d, at most 40 cycles.
  task automatic wait_done(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_done", 64'(seen), 64'd1);
  endtask

  // Start one operation and abort it in the RUN cycle where COUNT==c.
  task automatic abort_at(input int d, input int c);
    bit found = 1'b0;
    bit dseen = 1'b0;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sft_my[d] === 1'b1 && cnt[d] == 4'(c)) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach", 64'(found), 64'd1);
    abort_i[d] = 1'b1;
    @(negedge clk);
    abort_i[d] = 1'b0;
    check("abort_ready", 64'(ready[d]), 64'd1);
    check("abort_count", 64'(cnt[d]), 64'd0);
    repeat (15) begin
      @(negedge clk);
      if (done[d] === 1'b1) dseen = 1'b1;
    end
    check("abort_no_done", 64'(dseen), 64'd0);
  endtask

  // Three operations with START and ACK held high; loads N_BITS+3 apart.
  task automatic back_to_back(input int d);
    int n = nb[d];
    int nl = 0;
    int lk [3] = '{-1, -1, -1};
    int first_done = -1;
    ack[d]   = 1'b1;
    start[d] = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (load_mx[d] === 1'b1) begin
        if (nl < 3) lk[nl] = k;
        nl++;
        if (nl == 3) start[d] = 1'b0;
      end
      if (done[d] === 1'b1 && first_done < 0) first_done = k;
      if (nl >= 3 && k >= lk[2] + n + 4) break;
    end
    ack[d] = 1'b0;
    check("b2b_loads", 64'(nl), 64'd3);
    check("b2b_first", 64'(lk[0]), 64'd0);
    check("b2b_gap1", 64'(lk[1] - lk[0]), 64'(n + 3));
    check("b2b_gap2", 64'(lk[2] - lk[1]), 64'(n + 3));
    check("b2b_done_edge", 64'(first_done), 64'(n + 1));
  endtask

  initial begin
    int loads0;
    int hold_ok;
    int done_k;
    int nsft;
    logic [15:0] pat;

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort_i[d] = 1'b0; ack[d] = 1'b0;
      mx_in[d] = '0; my_in[d] = '0;
    end

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_outputs", 64'(out_vec(0)), 64'h100);
    check("rst_count", 64'(cnt[0]), 64'd0);

    // Directed operation: MY_BIT pattern 1,0,1,1,0,0,0,0,1.
    mx_in[0] = 16'hBEEF;
    my_in[0] = 9'h10D;
    start[0] = 1'b1;
    pat = '0; nsft = 0; done_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      if (done[0] === 1'b1) begin
        done_k = k;
        break;
      end
      if (sft_my[0] === 1'b1 && sft_acc[0] === 1'b1) begin
        if (nsft < 16) pat[nsft] = add_en[0];
        nsft++;
      end
    end
    check("pattern", 64'(pat), 64'h10D);
    check("run_cycles", 64'(nsft), 64'd9);
    check("done_edge", 64'(done_k), 64'd10);
    check("product_lit", acc[0], 64'd13148451);

    // DONE holds with ACK low for 20 cycles, then ACK releases it.
    hold_ok = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_vec(0) === 9'b001000000) hold_ok++;
    end
    check("done_hold", 64'(hold_ok), 64'd20);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    check("ack_to_idle", 64'(ready[0]), 64'd1);
    @(negedge clk);

    // Abort in RUN cycle 4 and in the final RUN cycle.
    mx_in[0] = 16'h1234; my_in[0] = 9'h1FF;
    abort_at(0, 3);
    abort_at(0, 8);

    // START ignored in LOAD, RUN and DONE_ST; START+ACK goes to IDLE only.
    #1 loads0 = load_cnt[0];
    @(negedge clk);
    mx_in[0] = 16'hFFFF; my_in[0] = 9'h0AA;
    start[0] = 1'b1;
    @(negedge clk);               // LOAD; START still high
    @(negedge clk);               // RUN
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    start[0] = 1'b1;
    @(negedge clk);
    check("start_in_done", 64'(done[0]), 64'd1);
    ack[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ack[0]   = 1'b0;
    check("start_ack_idle", 64'(ready[0]), 64'd1);
    @(negedge clk);
    check("start_ack_noload", 64'(ready[0]), 64'd1);
    #1 check("single_load", 64'(load_cnt[0] - loads0), 64'd1);

    // Back-to-back for both widths.
    back_to_back(0);
    back_to_back(1);

    // Asynchronous reset in the middle of RUN.
    start[0] = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(busy[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst9", 64'(out_vec(0)), 64'h100);
    check("async_rst4", 64'(out_vec(1)), 64'h100);
    check("async_rst_cnt", 64'(cnt[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        start[d]   = ($urandom_range(0, 2) == 0);
        abort_i[d] = ($urandom_range(0, 19) == 0);
        ack[d]     = ($urandom_range(0, 2) == 0);
        mx_in[d]   = MX_W'($urandom);
        my_in[d]   = MY_W'($urandom);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort_i[d] = 1'b0; ack[d] = 1'b0;
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mult_seq_ctrl
